// File: rtl/spi_master_ctrl.sv
// SPI-RAM link initiator: serialises {cmd, data} frames MSB first on MOSI under SS_n,
// and for read-data frames captures MEM_WIDTH bits from MISO after the RAM turnaround.
module spi_master_ctrl #(
  parameter int MEM_WIDTH = 8,
  parameter int RD_WAIT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [MEM_WIDTH-1:0] req_data,
  output logic                 rsp_valid,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic                 seq_err,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic [2:0]           state_o
);

  localparam int FW = MEM_WIDTH + 2;
  localparam int CW = $clog2(FW + RD_WAIT + MEM_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_SHIFT   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_END     = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          shreg_q, shreg_d;
  logic [MEM_WIDTH-1:0]   cap_q, cap_d;
  logic [1:0]             cmd_q, cmd_d;
  logic                   flag_q, flag_d;
  logic                   seq_err_q, seq_err_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [MEM_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                   ss_n_q, ss_n_d;
  logic                   mosi_q, mosi_d;

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one frame is in flight.
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign seq_err   = seq_err_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign state_o   = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    cap_d       = cap_q;
    cmd_d       = cmd_q;
    flag_d      = flag_q;
    seq_err_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          shreg_d = {req_cmd, req_data};
          cmd_d   = req_cmd;
          state_d = S_START;
          if (req_cmd == 2'b10) flag_d = 1'b1;
          if (req_cmd == 2'b11) begin
            flag_d    = 1'b0;
            seq_err_d = ~flag_q;
          end
        end
      end
      // START repeats cmd[1] without shifting: the slave decodes it before the frame proper.
      S_START: begin
        state_d = S_SHIFT;
        cnt_d   = CW'(FW);
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          if (cmd_q != 2'b11) begin
            state_d = S_END;
          end else if (RD_WAIT == 0) begin
            state_d = S_CAPTURE;
            cnt_d   = CW'(MEM_WIDTH);
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(RD_WAIT);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_CAPTURE;
          cnt_d   = CW'(MEM_WIDTH);
        end
      end
      S_CAPTURE: begin
        cap_d = {cap_q[MEM_WIDTH-2:0], MISO};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_END;
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Pin registers are loaded with the values belonging to the state being entered.
    ss_n_d = !(state_d == S_START || state_d == S_SHIFT ||
               state_d == S_WAIT  || state_d == S_CAPTURE);
    if (state_d == S_START || state_d == S_SHIFT) mosi_d = shreg_d[FW-1];
    if (state_d == S_END && cmd_q == 2'b11) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = cap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      cap_q       <= '0;
      cmd_q       <= '0;
      flag_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      cmd_q       <= cmd_d;
      flag_q      <= flag_d;
      seq_err_q   <= seq_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

endmodule
